// File: rtl/hazard_ctrl.sv
// Hazard control for the five-stage pipeline: EX operand forwarding, load-use
// stall, taken-branch flush and stall sequencing for the multi-cycle MDU.
module hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_is_mdu,
    input  logic        ex_mdu_div,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        flush_ifid,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [31:0] stall_count
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mdu_stall;
    logic             w_mdu_start;
    logic             w_lu;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] b_rd,
        input logic       b_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (b_we && (b_rd != 5'd0) && (b_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every signal written in an always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mdu_stall = 1'b0;
        w_mdu_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ex_is_mdu) begin
                    w_mdu_start = 1'b1;
                    w_mdu_stall = 1'b1;
                    w_cnt_nxt   = ex_mdu_div ? DIV_CNT : MUL_CNT;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt != '0) begin
                    w_mdu_stall = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // While reset is asserted every combinational output sits at its default.
    always_comb begin
        ForwardA     = 2'b00;
        ForwardB     = 2'b00;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        flush_ifid   = 1'b0;
        mdu_start    = 1'b0;
        mdu_busy     = 1'b0;
        if (rst_n) begin
            ForwardA  = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            ForwardB  = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            mdu_start = w_mdu_start;
            mdu_busy  = w_mdu_stall;
            if (w_mdu_stall) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                // The wrong-path instruction in ID is squashed, so its load-use stall is moot.
                flush_ifid  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            stall_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!pc_write) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational vectors plus
// hand-written MDU, branch and reset sequences, compared through a scoreboard.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_mdu, ex_mdu_div;
    logic        ex_branch_taken, mem_reg_write, wb_reg_write;
    logic [1:0]  ForwardA, ForwardB;
    logic        pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
    logic        flush_ifid, mdu_start, mdu_busy;
    logic [31:0] stall_count;

    hazard_ctrl #(
        .MUL_LAT(3),
        .DIV_LAT(32),
        .CNT_W  (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_is_mdu      (ex_is_mdu),
        .ex_mdu_div     (ex_mdu_div),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_bubble   (exmem_bubble),
        .flush_ifid     (flush_ifid),
        .mdu_start      (mdu_start),
        .mdu_busy       (mdu_busy),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fa, fb;
        logic       pc, ifid, idexw, bub, exb, fl, start, busy;
    } exp_t;

    typedef struct {
        logic [4:0] ex_rs1, ex_rs2, mem_rd, wb_rd, id_rs1, id_rs2, ex_rd;
        logic       mem_we, wb_we, u1, u2, ld, br;
        logic [1:0] fa, fb;
        logic       pc, bub, fl;
    } vec_t;

    localparam int NVEC = 16;
    vec_t        vecs[NVEC];
    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [4:0] ers1, input logic [4:0] ers2,
        input logic [4:0] mrd,  input logic mwe,
        input logic [4:0] wrd,  input logic wwe,
        input logic [4:0] irs1, input logic [4:0] irs2,
        input logic u1, input logic u2,
        input logic [4:0] erd, input logic ld, input logic br,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic pc, input logic bub, input logic fl
    );
        vec_t v;
        v.ex_rs1 = ers1; v.ex_rs2 = ers2; v.mem_rd = mrd; v.mem_we = mwe;
        v.wb_rd = wrd; v.wb_we = wwe; v.id_rs1 = irs1; v.id_rs2 = irs2;
        v.u1 = u1; v.u2 = u2; v.ex_rd = erd; v.ld = ld; v.br = br;
        v.fa = fa; v.fb = fb; v.pc = pc; v.bub = bub; v.fl = fl;
        return v;
    endfunction

    function automatic exp_t e_def();
        exp_t e;
        e.fa = 2'b00; e.fb = 2'b00; e.pc = 1'b1; e.ifid = 1'b1; e.idexw = 1'b1;
        e.bub = 1'b0; e.exb = 1'b0; e.fl = 1'b0; e.start = 1'b0; e.busy = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_mdu(input logic start);
        exp_t e;
        e = e_def();
        e.pc = 1'b0; e.ifid = 1'b0; e.idexw = 1'b0; e.exb = 1'b1;
        e.start = start; e.busy = 1'b1;
        return e;
    endfunction

    task automatic drive_zero();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_is_mdu = 0; ex_mdu_div = 0; ex_branch_taken = 0;
        mem_reg_write = 0; wb_reg_write = 0;
    endtask

    // Push the expectation, compare at the falling edge, then step past the next rising edge.
    task automatic expect_cycle(input exp_t e, input string tag);
        exp_t g;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            check({tag, ".ForwardA"},     32'(ForwardA),     32'(g.fa));
            check({tag, ".ForwardB"},     32'(ForwardB),     32'(g.fb));
            check({tag, ".pc_write"},     32'(pc_write),     32'(g.pc));
            check({tag, ".ifid_write"},   32'(ifid_write),   32'(g.ifid));
            check({tag, ".idex_write"},   32'(idex_write),   32'(g.idexw));
            check({tag, ".idex_bubble"},  32'(idex_bubble),  32'(g.bub));
            check({tag, ".exmem_bubble"}, 32'(exmem_bubble), 32'(g.exb));
            check({tag, ".flush_ifid"},   32'(flush_ifid),   32'(g.fl));
            check({tag, ".mdu_start"},    32'(mdu_start),    32'(g.start));
            check({tag, ".mdu_busy"},     32'(mdu_busy),     32'(g.busy));
            check({tag, ".stall_count"},  stall_count,       exp_stalls);
            if (!rst_n) exp_stalls = 32'd0;
            else if (!g.pc) exp_stalls = exp_stalls + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_checks   = 0;
        n_fail     = 0;
        exp_stalls = 32'd0;

        //               ers1 ers2 mrd mwe wrd wwe irs1 irs2 u1 u2 erd ld br   fa     fb    pc bub fl
        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[1]  = mkv(5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 0, 0);
        vecs[2]  = mkv(5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
        vecs[3]  = mkv(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[4]  = mkv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[5]  = mkv(9, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0);
        vecs[6]  = mkv(3, 4, 4, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 1, 0, 0);
        vecs[7]  = mkv(0, 6, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 0, 2'b00, 2'b00, 0, 1, 0);
        vecs[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 7, 1, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[11] = mkv(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 7, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[12] = mkv(0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 12, 1, 0, 2'b00, 2'b00, 0, 1, 0);
        vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 1, 2'b00, 2'b00, 1, 1, 1);
        vecs[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1);
        vecs[15] = mkv(2, 2, 2, 1, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2'b10, 2'b10, 0, 1, 0);

        // Reset with hazard-requesting inputs: outputs must stay at defaults.
        rst_n = 1'b0;
        drive_zero();
        ex_is_mdu = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
        @(posedge clk);
        #1;
        expect_cycle(e_def(), "reset");

        rst_n = 1'b1;
        drive_zero();
        for (int i = 0; i < NVEC; i++) begin
            ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
            mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_we;
            wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_we;
            id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].ex_rd; ex_mem_read = vecs[i].ld; ex_branch_taken = vecs[i].br;
            e = e_def();
            e.fa = vecs[i].fa; e.fb = vecs[i].fb; e.pc = vecs[i].pc;
            e.ifid = vecs[i].pc; e.bub = vecs[i].bub; e.fl = vecs[i].fl;
            expect_cycle(e, $sformatf("vec%0d", i));
        end

        // Multiply: three stall cycles; a branch request during the stall is ignored.
        drive_zero();
        ex_is_mdu = 1;
        expect_cycle(e_mdu(1'b1), "mul1");
        ex_branch_taken = 1;
        expect_cycle(e_mdu(1'b0), "mul2");
        ex_branch_taken = 0;
        expect_cycle(e_mdu(1'b0), "mul3");
        expect_cycle(e_def(), "mul_done");
        ex_is_mdu = 0;
        expect_cycle(e_def(), "mul_idle");

        // Divide: 32 stall cycles; toggling ex_mdu_div mid-run must not matter.
        ex_is_mdu = 1; ex_mdu_div = 1;
        expect_cycle(e_mdu(1'b1), "div1");
        for (int k = 2; k <= 32; k++) begin
            if (k == 10 || k == 25) ex_mdu_div = 0;
            if (k == 20) ex_mdu_div = 1;
            expect_cycle(e_mdu(1'b0), $sformatf("div%0d", k));
        end
        expect_cycle(e_def(), "div_done");
        ex_is_mdu = 0; ex_mdu_div = 0;
        expect_cycle(e_def(), "div_idle");

        // Reset asserted on the 5th cycle of a divide aborts it and clears the counter.
        ex_is_mdu = 1; ex_mdu_div = 1;
        expect_cycle(e_mdu(1'b1), "rdiv1");
        for (int k = 2; k <= 4; k++) begin
            expect_cycle(e_mdu(1'b0), $sformatf("rdiv%0d", k));
        end
        rst_n = 1'b0;
        expect_cycle(e_def(), "rdiv5_reset");
        rst_n = 1'b1;
        ex_is_mdu = 0; ex_mdu_div = 0;
        expect_cycle(e_def(), "post_reset");

        // Single load-use stall after reset, then the counter must read exactly 1.
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1;
        e = e_def();
        e.pc = 0; e.ifid = 0; e.bub = 1;
        expect_cycle(e, "lu_after_reset");
        drive_zero();
        expect_cycle(e_def(), "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
